// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed 4-digit active-low seven-segment
// bus and rebuilds the displayed 16-bit hex word and its decimal points.
// A digit is accepted once its (anode, catode) sample has been captured
// STABLE_CYCLES times in a row. A frame is published once all four digits
// have been accepted.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  catode,
  output logic [15:0] value,
  output logic [3:0]  dp_out,
  output logic        value_valid,
  output logic        decode_err
);

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

  state_t      state, state_next;
  logic [3:0]  s_an;
  logic [7:0]  s_cat;
  logic [7:0]  count, count_next;
  logic [3:0]  seen;
  logic [3:0]  hold_nib [4];
  logic [3:0]  hold_dp;

  logic        valid_sel;
  logic [1:0]  idx;
  logic        same;
  logic        accept;
  logic        pat_ok;
  logic [3:0]  pat_nib;
  logic [3:0]  seen_new;
  logic [15:0] frame_value;
  logic [3:0]  frame_dp;

  // Active-low segment pattern to hex nibble; catode[7] (dp) is not part of it.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h40:   seg_decode = {1'b1, 4'h0};
      7'h79:   seg_decode = {1'b1, 4'h1};
      7'h24:   seg_decode = {1'b1, 4'h2};
      7'h30:   seg_decode = {1'b1, 4'h3};
      7'h19:   seg_decode = {1'b1, 4'h4};
      7'h12:   seg_decode = {1'b1, 4'h5};
      7'h02:   seg_decode = {1'b1, 4'h6};
      7'h78:   seg_decode = {1'b1, 4'h7};
      7'h00:   seg_decode = {1'b1, 4'h8};
      7'h10:   seg_decode = {1'b1, 4'h9};
      7'h08:   seg_decode = {1'b1, 4'hA};
      7'h03:   seg_decode = {1'b1, 4'hB};
      7'h46:   seg_decode = {1'b1, 4'hC};
      7'h21:   seg_decode = {1'b1, 4'hD};
      7'h06:   seg_decode = {1'b1, 4'hE};
      7'h0E:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Select decode and pattern decode of the sample being captured this edge.
  // A sample counts from the edge on which it enters s_an/s_cat, and is
  // compared against the sample those registers currently hold.
  always_comb begin
    valid_sel = 1'b1;
    idx       = 2'd0;
    case (anode)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: valid_sel = 1'b0;
    endcase
    same              = (anode == s_an) && (catode == s_cat);
    {pat_ok, pat_nib} = seg_decode(catode[6:0]);
  end

  // Stability counter and FSM next state; one accept per dwell.
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    if (!valid_sel) begin
      count_next = 8'd0;
      state_next = WAIT;
    end else begin
      if (!same)
        count_next = 8'd1;
      else if (count != STABLE_LIMIT)
        count_next = count + 8'd1;

      if (state == HOLD && same) begin
        state_next = HOLD;
      end else if (count_next == STABLE_LIMIT) begin
        state_next = HOLD;
        accept     = 1'b1;
      end else begin
        state_next = SETTLE;
      end
    end
  end

  // Frame image as it would look with the digit accepted this edge merged in.
  assign seen_new = seen | (4'b0001 << idx);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_frame
      assign frame_value[4*gi +: 4] = (accept && pat_ok && idx == 2'(gi)) ? pat_nib : hold_nib[gi];
      assign frame_dp[gi]           = (accept && pat_ok && idx == 2'(gi)) ? ~catode[7] : hold_dp[gi];
    end
  endgenerate

  // Input sample registers, counter and state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_an  <= 4'hF;
      s_cat <= 8'hFF;
      count <= 8'd0;
      state <= WAIT;
    end else begin
      s_an  <= anode;
      s_cat <= catode;
      count <= count_next;
      state <= state_next;
    end
  end

  // Digit holding registers, seen mask and published frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen        <= 4'd0;
      hold_dp     <= 4'd0;
      hold_nib    <= '{default: 4'd0};
      value       <= 16'd0;
      dp_out      <= 4'd0;
      value_valid <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      decode_err  <= 1'b0;
      if (accept) begin
        if (pat_ok) begin
          hold_nib[idx] <= pat_nib;
          hold_dp[idx]  <= ~catode[7];
          if (seen_new == 4'hF) begin
            value       <= frame_value;
            dp_out      <= frame_dp;
            value_valid <= 1'b1;
            seen        <= 4'd0;
          end else begin
            seen <= seen_new;
          end
        end else begin
          decode_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: drives digit dwells, pushes the expected frame
// into a scoreboard and compares it whenever value_valid pulses.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic        value_valid;
  logic        decode_err;

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .anode       (anode),
    .catode      (catode),
    .value       (value),
    .dp_out      (dp_out),
    .value_valid (value_valid),
    .decode_err  (decode_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int bad_change = 0;
  int last_valid_cyc = 0;
  int start4;
  logic [15:0] prev_val = 16'd0;
  logic [3:0]  prev_dp  = 4'd0;
  logic [19:0] sb_q [$];   // {dp, value}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got %h exp %h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every frame pulse.
  always @(negedge clk) begin
    logic [19:0] exp_frame;
    if (value_valid && decode_err) both_cnt++;
    if (decode_err) err_cnt++;
    if (reset && !value_valid && (value !== prev_val || dp_out !== prev_dp)) bad_change++;
    prev_val = value;
    prev_dp  = dp_out;
    if (value_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (sb_q.size() > 0) begin
        exp_frame = sb_q.pop_front();
        check("frame_value", {16'd0, value}, {16'd0, exp_frame[15:0]});
        check("frame_dp", {28'd0, dp_out}, {28'd0, exp_frame[19:16]});
      end else begin
        check("sb_underflow", sb_q.size(), 1);
      end
    end
  end

  task automatic dwell(input logic [3:0] an, input logic [7:0] cat, input int n);
    anode  = an;
    catode = cat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;

  initial begin
    reset  = 1'b0;
    anode  = 4'hF;
    catode = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    // Digits driven while held in reset must not be accepted.
    dwell(D0, 8'h8E, 6);
    dwell(D1, 8'hB0, 6);
    check("rst_value", {16'd0, value}, 32'h0000);
    check("rst_dp", {28'd0, dp_out}, 32'h0);
    check("rst_valid_pulses", valid_cnt, 0);
    check("rst_err_pulses", err_cnt, 0);
    check("rst_valid_now", {31'd0, value_valid}, 0);

    reset = 1'b1;
    dwell(4'hF, 8'hFF, 3);

    // Clean scan of 0x1A3F, twice.
    sb_q.push_back({4'b0000, 16'h1A3F});
    dwell(D0, 8'h8E, 8);
    dwell(D1, 8'hB0, 8);
    dwell(D2, 8'h88, 8);
    start4 = cyc;
    dwell(D3, 8'hF9, 8);
    check("scan1_pulses", valid_cnt, 1);
    check("scan1_latency", last_valid_cyc, start4 + 4);
    sb_q.push_back({4'b0000, 16'h1A3F});
    dwell(D0, 8'h8E, 8);
    dwell(D1, 8'hB0, 8);
    dwell(D2, 8'h88, 8);
    dwell(D3, 8'hF9, 8);
    check("scan2_pulses", valid_cnt, 2);

    // Glitch: 3-cycle dwell of a '1' on digit 2 is too short to accept;
    // digit 2 only arrives later with a full dwell, completing 0x8000.
    sb_q.push_back({4'b0000, 16'h8000});
    dwell(D0, 8'hC0, 8);
    dwell(D1, 8'hC0, 8);
    dwell(D2, 8'hF9, 3);
    dwell(D3, 8'h80, 8);
    check("glitch_no_frame", valid_cnt, 2);
    dwell(D2, 8'hC0, 4);
    dwell(4'hF, 8'hFF, 2);
    check("glitch_pulses", valid_cnt, 3);

    // Invalid selects never accept.
    dwell(4'b1100, 8'hC0, 10);
    dwell(4'b1111, 8'hC0, 10);
    check("badsel_valid", valid_cnt, 3);
    check("badsel_err", err_cnt, 0);

    // Unknown pattern on digit 0: one decode_err, frame waits for legal digit 0.
    sb_q.push_back({4'b0000, 16'h4321});
    dwell(D1, 8'hA4, 8);
    dwell(D2, 8'hB0, 8);
    dwell(D3, 8'h99, 8);
    dwell(D0, 8'hFF, 8);
    check("badpat_err", err_cnt, 1);
    check("badpat_no_frame", valid_cnt, 3);
    dwell(D0, 8'hF9, 8);
    check("badpat_pulses", valid_cnt, 4);

    // Decimal point on digit 2, scan order 3,0,2,1.
    sb_q.push_back({4'b0100, 16'h0200});
    dwell(D3, 8'hC0, 6);
    dwell(D0, 8'hC0, 6);
    dwell(D2, 8'h24, 6);
    dwell(D1, 8'hC0, 6);
    check("dp_pulses", valid_cnt, 5);

    // Reset mid-frame drops digits 0 and 1.
    dwell(D0, 8'hC0, 8);
    dwell(D1, 8'hF9, 8);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midrst_value", {16'd0, value}, 32'h0000);
    dwell(D2, 8'hA4, 8);
    dwell(D3, 8'hB0, 8);
    check("midrst_no_frame", valid_cnt, 5);
    sb_q.push_back({4'b0000, 16'h3254});
    dwell(D0, 8'h99, 8);
    dwell(D1, 8'h92, 8);
    dwell(4'hF, 8'hFF, 4);
    check("midrst_pulses", valid_cnt, 6);

    check("sb_drained", sb_q.size(), 0);
    check("both_pulses", both_cnt, 0);
    check("silent_changes", bad_change, 0);
    check("total_err", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
